multicycle_ctrl: RTL and testbench

- Moore-style FSM that sequences the shared datapath as a multi-cycle RV32I core: fetch, decode, execute, memory and writeback each take their own cycle(s).
- A single ALU, the register file and a single memory port are reused across steps.
- Sits beside ID: consumes the opcode and the ALU zero flag, and drives every write enable and mux select.
- Adds a memory handshake watchdog, illegal-opcode trapping and a retired-instruction counter.

---
 rtl/multicycle_ctrl_if.sv | 21 ++
 rtl/multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multicycle controller and the shared memory port.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style sequencer for a multi-cycle RV32I datapath with a memory watchdog,
// illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   mem,
    input  logic [6:0]          op_i,
    input  logic                zero_i,
    output logic                ir_we_o,
    output logic                pc_we_o,
    output logic                pc_src_o,
    output logic                reg_we_o,
    output logic [1:0]          result_src_o,
    output logic [1:0]          alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [3:0]          state_o,
    output logic                illegal_o,
    output logic                bus_err_o,
    output logic [CNT_W-1:0]    instr_retired_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } state_e;

    localparam int unsigned WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST =
        WCNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic       memReq, memWe, irWe, pcWe, regWe;
    logic       isMemState, wdExpire, retireEvent;

    // Watchdog fires only when the last allowed wait cycle also sees no ready.
    assign wdExpire = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST) && !mem.mem_ready;

    always_comb begin
        state_d      = state_q;
        memReq       = 1'b0;
        memWe        = 1'b0;
        irWe         = 1'b0;
        pcWe         = 1'b0;
        regWe        = 1'b0;
        isMemState   = 1'b0;
        mem.addr_sel = 1'b0;
        pc_src_o     = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;

        case (state_q)
            FETCH: begin
                memReq      = 1'b1;
                isMemState  = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem.mem_ready) begin
                    irWe    = 1'b1;
                    pcWe    = 1'b1;
                    state_d = DECODE;
                end else if (wdExpire) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXEC_R;
                    OP_ITYPE:          state_d = EXEC_I;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = TRAP;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                state_d     = op_i[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memReq       = 1'b1;
                isMemState   = 1'b1;
                mem.addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    state_d = MEMWB;
                end else if (wdExpire) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            MEMWB: begin
                regWe        = 1'b1;
                result_src_o = 2'b01;
                state_d      = FETCH;
            end
            MEMWR: begin
                memReq       = 1'b1;
                memWe        = 1'b1;
                isMemState   = 1'b1;
                mem.addr_sel = 1'b1;
                if (mem.mem_ready) begin
                    state_d = FETCH;
                end else if (wdExpire) begin
                    bus_err_d = 1'b1;
                    state_d   = TRAP;
                end
            end
            EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b00;
                alu_op_o    = 2'b10;
                state_d     = ALUWB;
            end
            EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = ALUWB;
            end
            ALUWB: begin
                regWe   = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                pc_src_o    = 1'b1;
                pcWe        = zero_i;
                state_d     = FETCH;
            end
            JAL: begin
                regWe        = 1'b1;
                result_src_o = 2'b10;
                pcWe         = 1'b1;
                pc_src_o     = 1'b1;
                state_d      = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = TRAP;
        endcase

        // The counter restarts whenever a new state is entered, so it only runs while stalled.
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (isMemState && !mem.mem_ready) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end

        retireEvent = (state_d == FETCH) &&
                      ((state_q == MEMWB) || (state_q == MEMWR) || (state_q == ALUWB) ||
                       (state_q == BRANCH) || (state_q == JAL));
        retired_d = retireEvent ? (retired_q + CNT_W'(1)) : retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            retired_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            retired_q  <= retired_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Write enables are suppressed while reset is held so an abandoned instruction leaves no trace.
    assign mem.mem_req     = memReq & ~rst;
    assign mem.mem_we      = memWe & ~rst;
    assign ir_we_o         = irWe & ~rst;
    assign pc_we_o         = pcWe & ~rst;
    assign reg_we_o        = regWe & ~rst;
    assign state_o         = state_q;
    assign illegal_o       = illegal_q;
    assign bus_err_o       = bus_err_q;
    assign instr_retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: instruction sequencing, traps, watchdog and reset.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        irWe, pcWe, pcSrc, regWe, illegal, busErr;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, aluOp;
    logic [3:0]  stateObs;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if memBus ();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (memBus),
        .op_i            (op),
        .zero_i          (zero),
        .ir_we_o         (irWe),
        .pc_we_o         (pcWe),
        .pc_src_o        (pcSrc),
        .reg_we_o        (regWe),
        .result_src_o    (resultSrc),
        .alu_src_a_o     (aluSrcA),
        .alu_src_b_o     (aluSrcB),
        .alu_op_o        (aluOp),
        .state_o         (stateObs),
        .illegal_o       (illegal),
        .bus_err_o       (busErr),
        .instr_retired_o (retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [6:0] o, input logic z, input logic rdy);
        rst              = r;
        op               = o;
        zero             = z;
        memBus.mem_ready = rdy;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enables();
        return 32'({memBus.mem_req, memBus.mem_we, irWe, pcWe, regWe});
    endfunction

    initial begin
        // Reset with enables gated while rst is high
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1);
        nextCycle();
        checkOutput("rst state", 32'(stateObs), 32'd0);
        checkOutput("rst flags", 32'({illegal, busErr}), 32'd0);
        checkOutput("rst retired", retired, 32'd0);
        checkOutput("rst gated en", enables(), 32'b00000);

        // ADD: 0,1,6,8,0
        applyStimulus(1'b0, OP_ADD, 1'b0, 1'b1);
        checkOutput("add fetch state", 32'(stateObs), 32'd0);
        checkOutput("add fetch en", enables(), 32'b10110);
        checkOutput("add fetch alu", 32'({aluSrcA, aluSrcB, aluOp, memBus.addr_sel, pcSrc}), 32'b00_01_00_0_0);
        nextCycle();
        checkOutput("add decode state", 32'(stateObs), 32'd1);
        checkOutput("add decode alu", 32'({aluSrcA, aluSrcB, aluOp}), 32'b01_10_00);
        checkOutput("add decode en", enables(), 32'b00000);
        nextCycle();
        checkOutput("add exec state", 32'(stateObs), 32'd6);
        checkOutput("add exec alu", 32'({aluSrcA, aluSrcB, aluOp}), 32'b10_00_10);
        checkOutput("add exec en", enables(), 32'b00000);
        nextCycle();
        checkOutput("add wb state", 32'(stateObs), 32'd8);
        checkOutput("add wb en", enables(), 32'b00001);
        checkOutput("add wb src", 32'(resultSrc), 32'd0);
        nextCycle();
        checkOutput("add done state", 32'(stateObs), 32'd0);
        checkOutput("add retired", retired, 32'd1);

        // LW with three wait cycles in MEMRD
        applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("lw memadr state", 32'(stateObs), 32'd2);
        checkOutput("lw memadr alu", 32'({aluSrcA, aluSrcB, aluOp}), 32'b10_10_00);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, OP_LW, 1'b0, (i == 3));
            checkOutput("lw memrd state", 32'(stateObs), 32'd3);
            checkOutput("lw memrd req/addr/we", 32'({memBus.mem_req, memBus.addr_sel, memBus.mem_we}), 32'b110);
            nextCycle();
        end
        checkOutput("lw memwb state", 32'(stateObs), 32'd4);
        checkOutput("lw memwb en", enables(), 32'b00001);
        checkOutput("lw memwb src", 32'(resultSrc), 32'd1);
        nextCycle();
        checkOutput("lw done state", 32'(stateObs), 32'd0);
        checkOutput("lw retired", retired, 32'd2);

        // BEQ taken, then not taken
        applyStimulus(1'b0, OP_BEQ, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq1 state", 32'(stateObs), 32'd9);
        checkOutput("beq1 en", enables(), 32'b00010);
        checkOutput("beq1 src/op", 32'({pcSrc, aluSrcA, aluSrcB, aluOp}), 32'b1_10_00_01);
        nextCycle();
        checkOutput("beq1 retired", retired, 32'd3);
        applyStimulus(1'b0, OP_BEQ, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("beq0 state", 32'(stateObs), 32'd9);
        checkOutput("beq0 en", enables(), 32'b00000);
        nextCycle();
        checkOutput("beq0 state after", 32'(stateObs), 32'd0);
        checkOutput("beq0 retired", retired, 32'd4);

        // JAL
        applyStimulus(1'b0, OP_JAL, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("jal state", 32'(stateObs), 32'd10);
        checkOutput("jal en", enables(), 32'b00011);
        checkOutput("jal src", 32'({pcSrc, resultSrc}), 32'b1_10);
        nextCycle();
        checkOutput("jal retired", retired, 32'd5);

        // SW zero-wait
        applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("sw state", 32'(stateObs), 32'd5);
        checkOutput("sw req/we/addr", 32'({memBus.mem_req, memBus.mem_we, memBus.addr_sel}), 32'b111);
        nextCycle();
        checkOutput("sw done state", 32'(stateObs), 32'd0);
        checkOutput("sw retired", retired, 32'd6);

        // ADDI
        applyStimulus(1'b0, OP_ADDI, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("addi state", 32'(stateObs), 32'd7);
        checkOutput("addi alu", 32'({aluSrcA, aluSrcB, aluOp}), 32'b10_10_10);
        nextCycle();
        checkOutput("addi wb state", 32'(stateObs), 32'd8);
        nextCycle();
        checkOutput("addi retired", retired, 32'd7);

        // Illegal opcode traps on cycle 3 and holds
        applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
        nextCycle();
        checkOutput("bad decode illegal", 32'(illegal), 32'd0);
        nextCycle();
        checkOutput("bad trap state", 32'(stateObs), 32'd11);
        checkOutput("bad illegal", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
            checkOutput("trap hold", 32'({stateObs, enables()[4:0], illegal}), {23'd0, 4'd11, 5'b00000, 1'b1});
            nextCycle();
        end
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b1);
        nextCycle();
        checkOutput("trap rst state", 32'(stateObs), 32'd0);
        checkOutput("trap rst illegal", 32'(illegal), 32'd0);
        checkOutput("trap rst retired", retired, 32'd0);

        // Watchdog expires after exactly 16 stalled FETCH cycles
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, OP_ADD, 1'b0, 1'b0);
            checkOutput("wd stall state", 32'(stateObs), 32'd0);
            nextCycle();
        end
        checkOutput("wd trap state", 32'(stateObs), 32'd11);
        checkOutput("wd bus_err", 32'(busErr), 32'd1);
        checkOutput("wd req dropped", 32'(memBus.mem_req), 32'd0);

        // Ready on the expiry cycle completes the fetch
        applyStimulus(1'b1, OP_ADD, 1'b0, 1'b0);
        nextCycle();
        checkOutput("wd2 rst bus_err", 32'(busErr), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, OP_ADD, 1'b0, (i == 16));
            checkOutput("wd2 fetch ir_we", 32'(irWe), 32'(i == 16));
            nextCycle();
        end
        checkOutput("wd2 decode state", 32'(stateObs), 32'd1);
        checkOutput("wd2 bus_err", 32'(busErr), 32'd0);

        // Reset during MEMWR abandons the store
        applyStimulus(1'b1, OP_SW, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, OP_SW, 1'b0, 1'b1);
        checkOutput("swrst state", 32'(stateObs), 32'd5);
        checkOutput("swrst gated", 32'({memBus.mem_req, memBus.mem_we}), 32'b00);
        nextCycle();
        checkOutput("swrst after state", 32'(stateObs), 32'd0);
        checkOutput("swrst retired", retired, 32'd0);
        applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
        checkOutput("swrst resume req", 32'(memBus.mem_req), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
